// File: rtl/led_pwm_fader_pkg.sv
// Shared types and helpers for the LED PWM fader: channel fade states,
// brightness ceiling and the optional gamma curve (used when LED_GAMMA_EN is defined).
package led_pkg;

    typedef enum logic [1:0] {
        OFF     = 2'd0,
        RISING  = 2'd1,
        ON      = 2'd2,
        FALLING = 2'd3
    } fade_state_t;

    function automatic int led_max(input int pwm_bits);
        return (1 << pwm_bits) - 1;
    endfunction

    // Square-law duty with full brightness pinned to MAX; supports up to 16-bit brightness.
    function automatic logic [31:0] gamma_duty(input logic [15:0] b, input int pwm_bits);
        logic [31:0] prod;
        prod = 32'(b) * 32'(b);
        if (32'(b) == 32'(led_max(pwm_bits))) begin
            return 32'(led_max(pwm_bits));
        end
        return prod >> pwm_bits;
    endfunction

endpackage

// File: rtl/led_pwm_fader_channel.sv
// One LED channel: fade FSM and brightness register, period-aligned duty latch and
// registered PWM compare. Gamma mapping is selected by LED_GAMMA_EN.
module led_fade_channel
    import led_pkg::*;
#(
    parameter int PWM_BITS = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                step_tick,
    input  logic                target_on,
    input  logic [PWM_BITS-1:0] pwm_cnt,
    output logic                led,
    output logic                at_target
);

    localparam logic [PWM_BITS-1:0] MAX = PWM_BITS'(led_max(PWM_BITS));
    localparam logic [PWM_BITS-1:0] ONE = PWM_BITS'(1);

    fade_state_t         state, state_next;
    logic [PWM_BITS-1:0] bright, bright_next;
    logic [PWM_BITS-1:0] duty_val, duty_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= OFF;
            bright <= '0;
        end else begin
            state  <= state_next;
            bright <= bright_next;
        end
    end

    // A reversal that lands on an end stop goes straight to OFF/ON so the state always matches b.
    always_comb begin
        state_next  = state;
        bright_next = bright;
        if (step_tick) begin
            case (state)
                OFF: begin
                    if (target_on) begin
                        state_next  = RISING;
                        bright_next = ONE;
                    end
                end
                RISING, FALLING: begin
                    if (target_on) begin
                        bright_next = bright + ONE;
                        state_next  = (bright == MAX - ONE) ? ON : RISING;
                    end else begin
                        bright_next = bright - ONE;
                        state_next  = (bright == ONE) ? OFF : FALLING;
                    end
                end
                ON: begin
                    if (!target_on) begin
                        state_next  = FALLING;
                        bright_next = MAX - ONE;
                    end
                end
                default: state_next = OFF;
            endcase
        end
    end

    always_comb begin
        at_target = target_on ? (bright == MAX) : (bright == '0);
`ifdef LED_GAMMA_EN
        duty_val  = PWM_BITS'(gamma_duty(16'(bright), PWM_BITS));
`else
        duty_val  = bright;
`endif
    end

    // Duty only changes at the period boundary so a PWM period is never cut short.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            duty_q <= '0;
            led    <= 1'b0;
        end else begin
            if (pwm_cnt == MAX) begin
                duty_q <= duty_val;
            end
            led <= (duty_q == MAX) || (pwm_cnt < duty_q);
        end
    end

endmodule

// File: rtl/led_pwm_fader.sv
// LED PWM fader top: registers the pattern, runs the shared step and PWM counters and
// reduces per-channel settle flags. Optional gamma curve via LED_GAMMA_EN.
module led_pwm_fader
    import led_pkg::*;
#(
    parameter int NUM_LEDS = 4,
    parameter int PWM_BITS = 8,
    parameter int STEP_DIV = 4096
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUM_LEDS-1:0] pattern_in,
    output logic [NUM_LEDS-1:0] leds,
    output logic                settled
);

    localparam int STEP_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEP_DIV - 1);

    logic [NUM_LEDS-1:0] pattern_q;
    logic [NUM_LEDS-1:0] at_target;
    logic [STEP_W-1:0]   step_cnt;
    logic [PWM_BITS-1:0] pwm_cnt;
    logic                step_tick;

    assign step_tick = (step_cnt == STEP_LAST);

    // pwm_cnt relies on natural wrap from MAX back to 0.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pattern_q <= '0;
            step_cnt  <= '0;
            pwm_cnt   <= '0;
            settled   <= 1'b1;
        end else begin
            pattern_q <= pattern_in;
            step_cnt  <= step_tick ? '0 : step_cnt + STEP_W'(1);
            pwm_cnt   <= pwm_cnt + PWM_BITS'(1);
            settled   <= &at_target;
        end
    end

    for (genvar i = 0; i < NUM_LEDS; i++) begin : g_ch
        led_fade_channel #(
            .PWM_BITS (PWM_BITS)
        ) u_ch (
            .clk       (clk),
            .rst_n     (rst_n),
            .step_tick (step_tick),
            .target_on (pattern_q[i]),
            .pwm_cnt   (pwm_cnt),
            .led       (leds[i]),
            .at_target (at_target[i])
        );
    end

endmodule
